servo_pwm_bank: RTL and testbench
=================================

SERVO_PWM_BANK -- requirements
Module: servo_pwm_bank

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- NUM_CH, 3, number of servo/motor channels (>=1).
- CNT_W, 20, width of the period counter and pulse values.
- PERIOD, 1000000, clocks per PWM frame (20 ms at 50 MHz).
- MIN_PULSE, 50000, minimum legal high time in clocks.
- MAX_PULSE, 100000, maximum legal high time in clocks.
- SLEW, 2048, maximum change in applied pulse per frame, in clocks.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning. Clock and reset are listed first.
- clock, in, 1, single system clock.
- resetn, in, 1, asynchronous, active-low reset.
- enable, in, 1, frame generation enable.
- wr_en, in, 1, single-cycle write strobe.
- wr_ch, in, CH_W, channel index; CH_W = max(1, clog2(NUM_CH)).
- wr_pulse, in, CNT_W, requested high time in clocks.
- pwm_out, out, NUM_CH, per-channel PWM outputs.
- period_start, out, 1, one-cycle frame marker.
- busy, out, NUM_CH, per-channel flag: applied pulse differs from target.
- wr_clamped, out, 1, one-cycle flag: the last accepted write was clamped.
REQ-003 All outputs SHALL be registered; no output path is combinational from an input.

Function
REQ-004 Frame counter cnt SHALL count 0..PERIOD-1 and wrap to 0 while enable=1; while enable=0 it SHALL be held at 0.
REQ-005 Timing of pwm_out and period_start relative to cnt:
- period_start SHALL be 1 in the cycle after any cycle with enable=1 and cnt=0, and 0 otherwise.
- pwm_out[i] SHALL be 1 in the cycle after a cycle with enable=1 and cnt < cur[i], and 0 otherwise.
- Consequence: period_start and the rising edge of pwm_out are aligned.
REQ-006 Each channel SHALL hold a target register tgt[i] and an applied register cur[i], both CNT_W wide.
REQ-007 Write acceptance and clamping:
- A write is accepted when wr_en=1 and wr_ch<NUM_CH; writes with wr_ch>=NUM_CH SHALL be ignored, with no state change and wr_clamped=0.
- An accepted write SHALL set tgt[wr_ch] to wr_pulse clamped to [MIN_PULSE, MAX_PULSE] on the next edge.
- wr_clamped SHALL be 1 in the cycle after an accepted write whose value was clamped, and 0 otherwise.
REQ-008 Slew update of cur[i]:
- cur[i] SHALL update only on the edge where cnt wraps from PERIOD-1 to 0 with enable=1.
- Update rule: if |tgt-cur| <= SLEW then cur := tgt; else cur moves toward tgt by exactly SLEW.
- Arithmetic SHALL be unsigned with no overflow or underflow; cur always stays within [MIN_PULSE, MAX_PULSE].
REQ-009 Timing of updates relative to writes and frames:
- A write in the same cycle as the wrap edge SHALL NOT affect that slew step; the pre-write tgt is used.
- cur never changes mid-frame, so each frame's pulse is glitch-free.
REQ-010 busy[i] SHALL be registered as (cur[i] != tgt[i]), reflecting the register values after each edge.
REQ-011 Disable and re-enable behaviour:
- When enable falls mid-frame, pwm_out and period_start SHALL be 0 from the next cycle.
- cnt SHALL return to 0; tgt and cur SHALL be retained.
- Writes SHALL still be accepted while disabled.
- On re-enable, a new frame SHALL start from cnt=0.

Reset
REQ-012 Asserting resetn=0 SHALL immediately set:
- cnt=0;
- tgt[i]=cur[i]=(MIN_PULSE+MAX_PULSE)/2, truncated;
- pwm_out=0, period_start=0, busy=0, wr_clamped=0.
REQ-013 Reset asserted mid-frame or mid-slew SHALL abandon the frame and the slew with no partial pulse after deassertion; the first frame starts at cnt=0 once enable=1.

Verification (bench parameters NUM_CH=3, PERIOD=100, MIN_PULSE=10, MAX_PULSE=20, SLEW=3)
REQ-014 Reset then enable=1: period_start every 100 cycles; each pwm_out high exactly 15 cycles per frame, rising aligned with period_start; busy=000.
REQ-015 Write ch1=20: busy[1]=1; ch1 high times 15, 18, 20, 20 in successive frames; busy[1] returns to 0 after the frame in which 20 is reached.
REQ-016 Write ch0=5: wr_clamped=1 for one cycle; tgt0=10; high times 12, 10. Write ch2=20 then ch2=5 before the wrap edge: the final tgt2=10 is applied.
REQ-017 Write wr_ch=3: no state change, wr_clamped=0. Write coincident with the wrap edge: the step uses the old tgt, and the new value takes effect from the following wrap.
REQ-018 Drop enable at cnt=7: all outputs 0 from the next cycle. Re-enable: the frame restarts at cnt=0 with the retained cur.
REQ-019 Pulse resetn low mid-slew: all outputs 0 immediately; cur and tgt equal 15 for all channels after release.

Source files
------------

// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank
//   Bank of NUM_CH servo/motor PWM channels sharing one frame counter.
//   Every channel has a target high time (tgt) set by writes, clamped to
//   [MIN_PULSE, MAX_PULSE], and an applied high time (cur). cur moves
//   toward tgt by at most SLEW clocks, and only at frame wrap, so a pulse
//   never changes inside a frame.
//
// Ports
//   clock        system clock
//   resetn       asynchronous active-low reset
//   enable       frame generation enable (counter held at 0 when low)
//   wr_en        single-cycle write strobe
//   wr_ch        channel index for the write (out-of-range index ignored)
//   wr_pulse     requested high time in clocks
//   pwm_out      per-channel PWM outputs (registered)
//   period_start one-cycle frame marker, aligned with the pwm rising edge
//   busy         per-channel flag: applied pulse differs from target
//   wr_clamped   one-cycle flag: the last accepted write was clamped
module servo_pwm_bank #(
  parameter int NUM_CH    = 3,
  parameter int CNT_W     = 20,
  parameter int PERIOD    = 1000000,
  parameter int MIN_PULSE = 50000,
  parameter int MAX_PULSE = 100000,
  parameter int SLEW      = 2048,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_pulse,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start,
  output logic [NUM_CH-1:0] busy,
  output logic              wr_clamped
);

  localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] MAX_P  = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0] MID_P  = CNT_W'((MIN_PULSE + MAX_PULSE) / 2);
  localparam logic [CNT_W-1:0] SLEW_P = CNT_W'(SLEW);
  localparam logic [CNT_W-1:0] LAST_P = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  tgt_q [NUM_CH];
  logic [CNT_W-1:0]  tgt_d [NUM_CH];
  logic [CNT_W-1:0]  cur_q [NUM_CH];
  logic [CNT_W-1:0]  cur_d [NUM_CH];
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [NUM_CH-1:0] busy_q, busy_d;
  logic              period_start_q, period_start_d;
  logic              wr_clamped_q, wr_clamped_d;

  logic              wr_ok;
  logic              wrap;
  logic [CNT_W-1:0]  wr_val;

  always_comb begin
    wr_ok  = wr_en && (32'(wr_ch) < 32'(NUM_CH));
    wrap   = enable && (cnt_q == LAST_P);
    wr_val = wr_pulse;
    if (wr_pulse < MIN_P) wr_val = MIN_P;
    else if (wr_pulse > MAX_P) wr_val = MAX_P;

    cnt_d          = (!enable || wrap) ? '0 : cnt_q + CNT_W'(1);
    period_start_d = enable && (cnt_q == '0);
    wr_clamped_d   = wr_ok && ((wr_pulse < MIN_P) || (wr_pulse > MAX_P));

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      tgt_d[i] = tgt_q[i];
      cur_d[i] = cur_q[i];
      // Slew step reads tgt_q, so a write landing on the wrap edge only
      // counts from the following wrap.
      if (wrap) begin
        if (tgt_q[i] > cur_q[i]) begin
          cur_d[i] = ((tgt_q[i] - cur_q[i]) <= SLEW_P) ? tgt_q[i] : cur_q[i] + SLEW_P;
        end else begin
          cur_d[i] = ((cur_q[i] - tgt_q[i]) <= SLEW_P) ? tgt_q[i] : cur_q[i] - SLEW_P;
        end
      end
      if (wr_ok && (wr_ch == CH_W'(i))) tgt_d[i] = wr_val;
      pwm_d[i]  = enable && (cnt_q < cur_q[i]);
      // Compared on next-state values so the registered flag matches the
      // registers as they stand after the same edge.
      busy_d[i] = (cur_d[i] != tgt_d[i]);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q          <= '0;
      pwm_q          <= '0;
      busy_q         <= '0;
      period_start_q <= 1'b0;
      wr_clamped_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        tgt_q[i] <= MID_P;
        cur_q[i] <= MID_P;
      end
    end else begin
      cnt_q          <= cnt_d;
      pwm_q          <= pwm_d;
      busy_q         <= busy_d;
      period_start_q <= period_start_d;
      wr_clamped_q   <= wr_clamped_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        tgt_q[i] <= tgt_d[i];
        cur_q[i] <= cur_d[i];
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign busy         = busy_q;
  assign wr_clamped   = wr_clamped_q;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// tb_servo_pwm_bank
//   Self-checking bench for servo_pwm_bank with NUM_CH=3, PERIOD=100,
//   MIN_PULSE=10, MAX_PULSE=20, SLEW=3. Expected per-frame high times and
//   flag values are queued as stimulus is planned and compared as frames
//   complete.
module tb_servo_pwm_bank;

  localparam int NUM_CH    = 3;
  localparam int CNT_W     = 20;
  localparam int PERIOD    = 100;
  localparam int MIN_PULSE = 10;
  localparam int MAX_PULSE = 20;
  localparam int SLEW      = 3;

  logic              clock = 1'b0;
  logic              resetn;
  logic              enable;
  logic              wr_en;
  logic [1:0]        wr_ch;
  logic [CNT_W-1:0]  wr_pulse;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_start;
  logic [NUM_CH-1:0] busy;
  logic              wr_clamped;

  servo_pwm_bank #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .PERIOD   (PERIOD),
    .MIN_PULSE(MIN_PULSE),
    .MAX_PULSE(MAX_PULSE),
    .SLEW     (SLEW)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .enable      (enable),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_pulse    (wr_pulse),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .busy        (busy),
    .wr_clamped  (wr_clamped)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    int         h0;
    int         h1;
    int         h2;
    logic [2:0] busy;
  } frame_exp_t;

  typedef struct {
    int         at;
    int         ch;
    int         val;
    logic [2:0] busy;
  } wr_cmd_t;

  frame_exp_t exp_q[$];
  wr_cmd_t    wq[$];

  int         n_checks = 0;
  int         n_errors = 0;
  logic       exp_clamp_now = 1'b0;
  logic       chk_busy_pend = 1'b0;
  logic [2:0] busy_pend = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_frame(input string tag, input int a, input int b, input int c,
                            input logic [2:0] bz);
    frame_exp_t e;
    e.tag = tag; e.h0 = a; e.h1 = b; e.h2 = c; e.busy = bz;
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input int at, input int ch, input int val, input logic [2:0] bz);
    wr_cmd_t c;
    c.at = at; c.ch = ch; c.val = val; c.busy = bz;
    wq.push_back(c);
  endtask

  task automatic apply_wr(input wr_cmd_t c);
    wr_en         = 1'b1;
    wr_ch         = c.ch[1:0];
    wr_pulse      = CNT_W'(c.val);
    exp_clamp_now = (c.ch < NUM_CH) && ((c.val < MIN_PULSE) || (c.val > MAX_PULSE));
    chk_busy_pend = 1'b1;
    busy_pend     = c.busy;
  endtask

  task automatic sample_wr_flags();
    check_eq("wr_clamped", {31'b0, wr_clamped}, {31'b0, exp_clamp_now});
    if (chk_busy_pend) check_eq("busy_after_wr", {29'b0, busy}, {29'b0, busy_pend});
    exp_clamp_now = 1'b0;
    chk_busy_pend = 1'b0;
  endtask

  task automatic wait_frame_start();
    for (int k = 0; k < 3 * PERIOD && period_start !== 1'b1; k++) @(negedge clock);
    if (period_start !== 1'b1) check_eq("frame_start_timeout", 32'd0, 32'd1);
  endtask

  // Measures one frame starting at the period_start cycle and leaves the
  // bench at the first cycle of the next frame.
  task automatic run_frame();
    frame_exp_t e;
    wr_cmd_t    c;
    int         hi[3];
    int         ps_n;
    wait_frame_start();
    if (exp_q.size() == 0) begin
      check_eq("exp_queue_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    for (int k = 0; k < 3; k++) hi[k] = 0;
    ps_n = 0;
    check_eq({e.tag, "_rise"}, {29'b0, pwm_out}, 32'd7);
    for (int j = 0; j < PERIOD; j++) begin
      sample_wr_flags();
      for (int k = 0; k < 3; k++) if (pwm_out[k]) hi[k]++;
      if (period_start) ps_n++;
      if (j == PERIOD - 1) check_eq({e.tag, "_busy"}, {29'b0, busy}, {29'b0, e.busy});
      wr_en = 1'b0;
      if (wq.size() > 0 && wq[0].at == j) begin
        c = wq.pop_front();
        apply_wr(c);
      end
      @(negedge clock);
    end
    check_eq({e.tag, "_hi0"}, hi[0], e.h0);
    check_eq({e.tag, "_hi1"}, hi[1], e.h1);
    check_eq({e.tag, "_hi2"}, hi[2], e.h2);
    check_eq({e.tag, "_ps"}, ps_n, 32'd1);
  endtask

  initial begin
    resetn   = 1'b0;
    enable   = 1'b0;
    wr_en    = 1'b0;
    wr_ch    = '0;
    wr_pulse = '0;
    repeat (3) @(negedge clock);
    check_eq("rst_pwm", {29'b0, pwm_out}, 32'd0);
    check_eq("rst_ps", {31'b0, period_start}, 32'd0);
    check_eq("rst_busy", {29'b0, busy}, 32'd0);
    check_eq("rst_clamp", {31'b0, wr_clamped}, 32'd0);
    resetn = 1'b1;
    @(negedge clock);
    enable = 1'b1;

    // Idle frames at the reset midpoint
    push_frame("init_a", 15, 15, 15, 3'b000);
    push_frame("init_b", 15, 15, 15, 3'b000);
    repeat (2) run_frame();

    // ch1 slews 15 -> 18 -> 20
    push_wr(5, 1, 20, 3'b010);
    push_frame("ch1_w",  15, 15, 15, 3'b010);
    push_frame("ch1_s1", 15, 18, 15, 3'b000);
    push_frame("ch1_s2", 15, 20, 15, 3'b000);
    push_frame("ch1_s3", 15, 20, 15, 3'b000);
    repeat (4) run_frame();

    // Clamped write on ch0; ch2 rewritten within one frame
    push_wr(5, 0, 5, 3'b001);
    push_wr(10, 2, 20, 3'b101);
    push_wr(20, 2, 5, 3'b101);
    push_frame("clamp_w",  15, 20, 15, 3'b101);
    push_frame("clamp_s1", 12, 20, 12, 3'b000);
    push_frame("clamp_s2", 10, 20, 10, 3'b000);
    repeat (3) run_frame();

    // Out-of-range channel ignored; write on the wrap edge waits a frame
    push_wr(5, 3, 5, 3'b000);
    push_wr(PERIOD - 2, 1, 10, 3'b010);
    push_frame("wrap_w",  10, 20, 10, 3'b010);
    push_frame("wrap_s1", 10, 20, 10, 3'b010);
    push_frame("wrap_s2", 10, 17, 10, 3'b010);
    push_frame("wrap_s3", 10, 14, 10, 3'b010);
    push_frame("wrap_s4", 10, 11, 10, 3'b000);
    push_frame("wrap_s5", 10, 10, 10, 3'b000);
    repeat (6) run_frame();

    // Start a slew on ch2 (cur2 becomes 13), then disable mid-frame
    push_wr(5, 2, 16, 3'b100);
    push_frame("pre_dis", 10, 10, 10, 3'b100);
    run_frame();
    wait_frame_start();
    repeat (6) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 10; k++) begin
      check_eq("dis_pwm", {29'b0, pwm_out}, 32'd0);
      check_eq("dis_ps", {31'b0, period_start}, 32'd0);
      @(negedge clock);
    end
    wr_en    = 1'b1;
    wr_ch    = 2'd0;
    wr_pulse = CNT_W'(13);
    @(negedge clock);
    wr_en = 1'b0;
    check_eq("dis_wr_clamp", {31'b0, wr_clamped}, 32'd0);
    check_eq("dis_wr_busy", {29'b0, busy}, 32'd5);
    check_eq("dis_wr_pwm", {29'b0, pwm_out}, 32'd0);
    enable = 1'b1;
    @(negedge clock);
    check_eq("reen_start", {31'b0, period_start}, 32'd1);
    push_frame("reen_f1", 10, 10, 13, 3'b000);
    push_frame("reen_f2", 13, 10, 16, 3'b000);
    repeat (2) run_frame();

    // Reset in the middle of a ch1 slew
    push_wr(5, 1, 20, 3'b010);
    push_frame("rst_w", 13, 10, 16, 3'b010);
    run_frame();
    wait_frame_start();
    repeat (5) @(negedge clock);
    check_eq("pre_rst_pwm", {29'b0, pwm_out}, 32'd7);
    #2 resetn = 1'b0;
    #1;
    check_eq("mid_rst_pwm", {29'b0, pwm_out}, 32'd0);
    check_eq("mid_rst_ps", {31'b0, period_start}, 32'd0);
    check_eq("mid_rst_busy", {29'b0, busy}, 32'd0);
    check_eq("mid_rst_clamp", {31'b0, wr_clamped}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    push_frame("post_rst_a", 15, 15, 15, 3'b000);
    push_frame("post_rst_b", 15, 15, 15, 3'b000);
    repeat (2) run_frame();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
